// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes per state.
// It handshakes with a shared instruction/data memory, traps illegal opcodes
// into an absorbing HALT state, and counts retired instructions.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [OPCODE_W-1:0] op_q;
    logic                retire;

    // Opcode classes are derived from the registered opcode only, so the IR
    // may change after DECODE without disturbing the instruction in flight.
    logic op_hi_zero;
    logic op_rtype;
    logic op_lw;
    logic op_sw;
    logic op_bne;
    logic live_legal;

    // True when the opcode belongs to the supported instruction set.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        logic ok;
        ok = 1'b0;
        if ((op >> 4) == '0) begin
            case (op[3:0])
                4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE: ok = 1'b1;
                default:                                         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // ALU operation code for a legal opcode's low nibble.
    function automatic logic [ALUOP_W-1:0] alu_code(input logic [3:0] op);
        logic [ALUOP_W-1:0] code;
        case (op)
            4'h0:              code = ALUOP_W'(0);
            4'h1:              code = ALUOP_W'(1);
            4'h2, 4'h8, 4'hA:  code = ALUOP_W'(2);
            4'h6, 4'hE:        code = ALUOP_W'(3);
            4'h7:              code = ALUOP_W'(4);
            default:           code = ALUOP_W'(0);
        endcase
        return code;
    endfunction

    assign state      = state_reg;
    assign live_legal = is_legal(opcode);
    assign op_hi_zero = ((op_q >> 4) == '0);
    assign op_rtype   = op_hi_zero && (op_q[3:0] == 4'h0 || op_q[3:0] == 4'h1 ||
                                       op_q[3:0] == 4'h2 || op_q[3:0] == 4'h6 ||
                                       op_q[3:0] == 4'h7);
    assign op_lw      = op_hi_zero && (op_q[3:0] == 4'h8);
    assign op_sw      = op_hi_zero && (op_q[3:0] == 4'hA);
    assign op_bne     = op_hi_zero && (op_q[3:0] == 4'hE);

    // Next-state, per-state strobes and the retire pulse; reset forces every
    // strobe low so memory never sees a request while the unit is in reset.
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = '0;
        retire     = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = live_legal ? EXEC : HALT;
            end
            EXEC: begin
                alu_op = alu_code(op_q[3:0]);
                if (op_lw || op_sw) begin
                    alu_src    = 1'b1;
                    state_next = MEM;
                end else if (op_bne) begin
                    if (!zero) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    retire     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = op_sw;
                if (mem_ready) begin
                    if (op_sw) begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = op_rtype;
                mem_to_reg = op_lw;
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            alu_op     = '0;
            retire     = 1'b0;
        end
    end

    // State register, opcode capture, sticky illegal flag and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            op_q      <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                op_q <= opcode;
                if (!live_legal) begin
                    illegal <= 1'b1;
                end
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process pushes a
// hand-written expected snapshot for every cycle it drives; a monitor pops
// and compares on the falling edge. A second instance with a 2-bit counter
// shares the inputs to exercise counter wrap.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  strb;
        logic [2:0]  aop;
        logic        ill;
        logic [15:0] ret;
    } exp_t;

    // Strobe vector order: mem_req mem_we iord ir_write pc_write pc_src
    //                      reg_dst reg_write alu_src mem_to_reg
    localparam logic [9:0] S_NONE    = 10'b0000000000;
    localparam logic [9:0] S_FETCH_W = 10'b1000000000;
    localparam logic [9:0] S_FETCH   = 10'b1001100000;
    localparam logic [9:0] S_WB_R    = 10'b0000001100;
    localparam logic [9:0] S_EXEC_M  = 10'b0000000010;
    localparam logic [9:0] S_MEM_LW  = 10'b1010000000;
    localparam logic [9:0] S_MEM_SW  = 10'b1110000000;
    localparam logic [9:0] S_WB_LW   = 10'b0000000101;
    localparam logic [9:0] S_BNE_T   = 10'b0000110000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic        mem_req_a, mem_we_a, iord_a, ir_write_a, pc_write_a, pc_src_a;
    logic        reg_dst_a, reg_write_a, alu_src_a, mem_to_reg_a, illegal_a;
    logic [2:0]  alu_op_a, state_a;
    logic [15:0] retired_a;
    logic        mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, pc_src_b;
    logic        reg_dst_b, reg_write_b, alu_src_b, mem_to_reg_b, illegal_b;
    logic [2:0]  alu_op_b, state_b;
    logic [1:0]  retired_b;
    logic [9:0]  strb_a, strb_b;

    int   checks = 0;
    int   failures = 0;
    int   exp_ret = 0;
    logic exp_ill = 1'b0;
    exp_t exp_q[$];

    multicycle_control dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a), .ir_write(ir_write_a),
        .pc_write(pc_write_a), .pc_src(pc_src_a), .reg_dst(reg_dst_a),
        .reg_write(reg_write_a), .alu_src(alu_src_a), .mem_to_reg(mem_to_reg_a),
        .alu_op(alu_op_a), .illegal(illegal_a), .state(state_a), .retired(retired_a)
    );

    multicycle_control #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_write(ir_write_b),
        .pc_write(pc_write_b), .pc_src(pc_src_b), .reg_dst(reg_dst_b),
        .reg_write(reg_write_b), .alu_src(alu_src_b), .mem_to_reg(mem_to_reg_b),
        .alu_op(alu_op_b), .illegal(illegal_b), .state(state_b), .retired(retired_b)
    );

    assign strb_a = {mem_req_a, mem_we_a, iord_a, ir_write_a, pc_write_a, pc_src_a,
                     reg_dst_a, reg_write_a, alu_src_a, mem_to_reg_a};
    assign strb_b = {mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, pc_src_b,
                     reg_dst_b, reg_write_b, alu_src_b, mem_to_reg_b};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected snapshot per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state_a",   32'(state_a),   32'(e.st));
            chk("strobes_a", 32'(strb_a),    32'(e.strb));
            chk("alu_op_a",  32'(alu_op_a),  32'(e.aop));
            chk("illegal_a", 32'(illegal_a), 32'(e.ill));
            chk("retired_a", 32'(retired_a), 32'(e.ret));
            chk("state_b",   32'(state_b),   32'(e.st));
            chk("strobes_b", 32'(strb_b),    32'(e.strb));
            chk("alu_op_b",  32'(alu_op_b),  32'(e.aop));
            chk("illegal_b", 32'(illegal_b), 32'(e.ill));
            chk("retired_b", 32'(retired_b), 32'(e.ret[1:0]));
            $display("cyc t=%0t st=%0d strb=%b aop=%0d ill=%0b ret=%0d ret2=%0d",
                     $time, state_a, strb_a, alu_op_a, illegal_a, retired_a, retired_b);
        end
    end

    // Drive one cycle of inputs and queue its expected snapshot.
    task automatic step(input logic rdy, input logic z, input logic [5:0] op,
                        input logic [2:0] st, input logic [9:0] sb,
                        input logic [2:0] aop, input logic ret);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        e.st   = st;
        e.strb = sb;
        e.aop  = aop;
        e.ill  = exp_ill;
        e.ret  = exp_ret[15:0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (ret) exp_ret++;
    endtask

    // One cycle with reset held, then release.
    task automatic do_reset();
        rst     = 1'b1;
        exp_ret = 0;
        exp_ill = 1'b0;
        step(1'b0, 1'b0, 6'h00, 3'd0, S_NONE, 3'd0, 1'b0);
        rst = 1'b0;
    endtask

    // ADD; the opcode input is changed after DECODE to prove op_q is used.
    task automatic do_add();
        step(1'b1, 1'b0, 6'h02, 3'd0, S_FETCH, 3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h02, 3'd1, S_NONE,  3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h08, 3'd2, S_NONE,  3'd2, 1'b0);
        step(1'b1, 1'b0, 6'h08, 3'd4, S_WB_R,  3'd0, 1'b1);
    endtask

    task automatic do_lw(input int waits);
        step(1'b1, 1'b0, 6'h08, 3'd0, S_FETCH,  3'd0, 1'b0);
        step(1'b0, 1'b0, 6'h08, 3'd1, S_NONE,   3'd0, 1'b0);
        step(1'b0, 1'b0, 6'h08, 3'd2, S_EXEC_M, 3'd2, 1'b0);
        for (int i = 0; i < waits; i++)
            step(1'b0, 1'b0, 6'h08, 3'd3, S_MEM_LW, 3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h08, 3'd3, S_MEM_LW, 3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h08, 3'd4, S_WB_LW,  3'd0, 1'b1);
    endtask

    task automatic do_bne(input logic z);
        step(1'b1, 1'b0, 6'h0E, 3'd0, S_FETCH, 3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0E, 3'd1, S_NONE,  3'd0, 1'b0);
        step(1'b1, z,    6'h0E, 3'd2, z ? S_NONE : S_BNE_T, 3'd3, 1'b1);
    endtask

    task automatic do_sw(input int fetch_waits);
        for (int i = 0; i < fetch_waits; i++)
            step(1'b0, 1'b0, 6'h0A, 3'd0, S_FETCH_W, 3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd0, S_FETCH,  3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd1, S_NONE,   3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd2, S_EXEC_M, 3'd2, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd3, S_MEM_SW, 3'd0, 1'b1);
    endtask

    // Illegal opcode: HALT after DECODE, strobes low whatever the inputs do.
    task automatic do_illegal(input logic [5:0] op);
        step(1'b1, 1'b0, op, 3'd0, S_FETCH, 3'd0, 1'b0);
        step(1'b1, 1'b0, op, 3'd1, S_NONE,  3'd0, 1'b0);
        exp_ill = 1'b1;
        for (int i = 0; i < 10; i++)
            step(1'b1, i[0], op, 3'd5, S_NONE, 3'd0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        do_add();
        do_lw(3);
        do_bne(1'b0);
        do_bne(1'b1);
        do_sw(1);
        // SW abandoned by reset during its second MEM wait cycle.
        step(1'b1, 1'b0, 6'h0A, 3'd0, S_FETCH,  3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd1, S_NONE,   3'd0, 1'b0);
        step(1'b1, 1'b0, 6'h0A, 3'd2, S_EXEC_M, 3'd2, 1'b0);
        step(1'b0, 1'b0, 6'h0A, 3'd3, S_MEM_SW, 3'd0, 1'b0);
        do_reset();
        // Five back-to-back ADDs: the 2-bit counter reads 1,2,3,0,1.
        for (int i = 0; i < 5; i++) do_add();
        do_illegal(6'h05);
        do_reset();
        do_illegal(6'h22);
        do_reset();
        do_add();
        step(1'b0, 1'b0, 6'h00, 3'd0, S_FETCH_W, 3'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the single-cycle opcode decoder in the MIPS datapath. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath strobes per state instead of per opcode. It handshakes with a single shared instruction/data memory through `mem_req`/`mem_ready`, traps illegal opcodes, and counts retired instructions. It sits between the instruction register and the datapath muxes, ALU and register file.

## Interface
- `OPCODE_W`, default 6: opcode width; decode uses `opcode[3:0]` and requires the upper bits to be 0.
- `ALUOP_W`, default 3: ALU operation code width; must be ≥ 3.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `opcode`  in  OPCODE_W: IR opcode field; valid from DECODE onward.
- `zero`  in  1: ALU zero flag; sampled in EXEC for BNE.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `mem_req`  out  1: memory access request; held until `mem_ready`.
- `mem_we`  out  1: write qualifier for `mem_req`.
- `iord`  out  1: memory address select; 0 = PC, 1 = ALU result.
- `ir_write`  out  1: load the IR.
- `pc_write`  out  1: load the PC.
- `pc_src`  out  1: PC source; 0 = PC+4, 1 = branch target.
- `reg_dst`  out  1: destination register select; 1 = rd, 0 = rt.
- `reg_write`  out  1: register file write enable.
- `alu_src`  out  1: ALU B input select; 1 = sign-extended immediate.
- `mem_to_reg`  out  1: write-back source select; 1 = memory data.
- `alu_op`  out  ALUOP_W: ALU operation code.
- `illegal`  out  1: sticky illegal-opcode flag.
- `state`  out  3: current state, for debug.
- `retired`  out  CNT_W: count of retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. States 6 and 7 are unreachable; if entered, the next state is FETCH.
- Opcode decode (the low 4 bits, with the upper bits 0):
  - AND=0x0 → alu_op 0, OR=0x1 → 1, ADD=0x2 → 2, SUB=0x6 → 3, SLT=0x7 → 4.
  - LW=0x8 and SW=0xA → alu_op 2.
  - BNE=0xE → alu_op 3.
  - Any other value, or any nonzero upper bit, is illegal.
- The opcode is registered into `op_q` on the DECODE cycle. EXEC, MEM and WB decode from `op_q`, never from the live `opcode`.
- FETCH:
  - Drives `mem_req`=1, `iord`=0.
  - In the `mem_ready` cycle it also drives `ir_write`=1, `pc_write`=1, `pc_src`=0, and the next state is DECODE.
  - Otherwise it stays in FETCH with the strobes held.
- DECODE (1 cycle):
  - Illegal opcode → HALT, and `illegal` is set.
  - Legal opcode → EXEC.
- EXEC (1 cycle): `alu_op` is taken from `op_q`.
  - R-type: `alu_src`=0, next state WB.
  - LW/SW: `alu_src`=1, next state MEM.
  - BNE: `alu_src`=0. If `zero`=0, drive `pc_write`=1 and `pc_src`=1. Next state FETCH; the instruction retires.
- MEM:
  - Drives `mem_req`=1, `iord`=1, `mem_we`=1 for SW only. Holds until `mem_ready`.
  - On completion: LW → WB; SW → FETCH and retires.
- WB (1 cycle):
  - Drives `reg_write`=1.
  - R-type: `reg_dst`=1, `mem_to_reg`=0. LW: `reg_dst`=0, `mem_to_reg`=1.
  - Next state FETCH; the instruction retires.
- HALT: absorbing state; all strobes are 0. Only `rst` exits it.
- Strobe defaults: every strobe not listed for a state is 0, and `alu_op` is 0 outside EXEC.
- `retired` increments by 1 on each retiring edge and wraps modulo 2^CNT_W without saturating.

## Timing
- Outputs are combinational from `state`, `op_q`, `zero` and `mem_ready`. `state`, `op_q`, `illegal` and `retired` are registers.
- Reset values: `state`=FETCH, `op_q`=0, `illegal`=0, `retired`=0.
- While `rst`=1, every strobe is forced to 0, including `mem_req`. `mem_req` rises in the first cycle after `rst` falls.
- Minimum latency per instruction, with `mem_ready` tied high: BNE 3 cycles, R-type 4, SW 4, LW 5.
- Each cycle `mem_ready` stays low in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- A request is never withdrawn: `mem_req`, `mem_we` and `iord` stay stable until completion.
- Reset asserted mid-access (FETCH or MEM): the state returns to FETCH asynchronously and the access is abandoned. No retire occurs and `retired` clears.
- A retire and a counter wrap on the same edge produce `retired`=0.

## Test plan
- ADD (0x02) with `mem_ready`=1 → state sequence 0,1,2,4,0. `alu_op`=2 in EXEC. `reg_write`=1 and `reg_dst`=1 only in WB. `retired` goes 0→1.
- LW (0x08) with `mem_ready` low for 3 MEM cycles → `mem_req`=1, `iord`=1, `mem_we`=0 held for 4 cycles. WB follows with `mem_to_reg`=1 and `reg_dst`=0. Total 8 cycles.
- BNE (0x0E): `zero`=0 → EXEC drives `pc_write`=1, `pc_src`=1. Repeat with `zero`=1 → `pc_write`=0. Both return to FETCH after 3 cycles.
- Opcode 0x05, then opcode 0x22 → HALT at the DECODE edge, `illegal`=1, all strobes 0 for 10 cycles; `rst` clears it.
- `rst` pulse during the second MEM wait cycle of SW → `mem_req` drops immediately, `state`=0, `retired`=0. `mem_req`=1 in the first cycle after release.
- `CNT_W`=2 with 5 back-to-back ADDs → `retired` reads 1,2,3,0,1.
